// File: rtl/c2bw_frame_sequencer_pkg.sv
// Shared types and widths for the Color2BW frame sequencer.
// Optional checksum accumulator is enabled by defining C2BW_CHECKSUM_EN.
package c2bw_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned CHK_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // States in which the sequencer reports itself as busy.
  function automatic logic state_busy(state_e s);
    return (s == FETCH) || (s == LOAD) || (s == WRITE);
  endfunction

endpackage

// File: rtl/c2bw_frame_sequencer_if.sv
// Control, channel-memory, Color2BW and output-buffer signals of the frame sequencer.
// The checksum signal exists only when C2BW_CHECKSUM_EN is defined.
interface c2bw_seq_if #(
  parameter int unsigned ADDR_W = 14
);
  import c2bw_pkg::*;

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;

  logic              rdEn;
  logic [ADDR_W-1:0] rdAddr;
  logic [PIX_W-1:0]  rdRed;
  logic [PIX_W-1:0]  rdGreen;
  logic [PIX_W-1:0]  rdBlue;

  logic [PIX_W-1:0]  colorRed;
  logic [PIX_W-1:0]  colorGreen;
  logic [PIX_W-1:0]  colorBlue;
  logic [PIX_W-1:0]  greyIn;

  logic              wrValid;
  logic              wrReady;
  logic [ADDR_W-1:0] wrAddr;
  logic [PIX_W-1:0]  wrData;
`ifdef C2BW_CHECKSUM_EN
  logic [CHK_W-1:0]  checksum;
`endif

  // Sequencer side.
  modport master (
    input  start, abort, rdRed, rdGreen, rdBlue, greyIn, wrReady,
    output busy, done, rdEn, rdAddr, colorRed, colorGreen, colorBlue,
           wrValid, wrAddr, wrData
`ifdef C2BW_CHECKSUM_EN
           , checksum
`endif
  );

  // Memories, Color2BW instance and output buffer side.
  modport slave (
    output start, abort, rdRed, rdGreen, rdBlue, greyIn, wrReady,
    input  busy, done, rdEn, rdAddr, colorRed, colorGreen, colorBlue,
           wrValid, wrAddr, wrData
`ifdef C2BW_CHECKSUM_EN
           , checksum
`endif
  );

endinterface

// File: rtl/c2bw_frame_sequencer_pixel_counter.sv
// Linear pixel address counter with synchronous clear, increment and last-pixel flag.
module c2bw_pixel_counter #(
  parameter int unsigned NPIX   = 16384,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (inc_i) begin
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == ADDR_W'(NPIX - 1));

endmodule

// File: rtl/c2bw_frame_sequencer.sv
// Walks a FRAME_W x FRAME_H RGB frame through an external Color2BW and writes grey bytes out.
// Define C2BW_CHECKSUM_EN to add a running 32-bit sum of written grey bytes.
module c2bw_frame_sequencer
  import c2bw_pkg::*;
#(
  parameter int unsigned FRAME_W = 128,
  parameter int unsigned FRAME_H = 128,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic       clk,
  input  logic       rst,
  c2bw_seq_if.master bus
);

  localparam int unsigned NPIX = FRAME_W * FRAME_H;

  state_e            state_q;
  state_e            state_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic              cnt_last;
  logic [ADDR_W-1:0] addr;

  logic              load_en;
  logic              xfer;

  logic              busy_q;
  logic              busy_d;
  logic              done_q;
  logic              done_d;
  logic              rd_en_q;
  logic              rd_en_d;
  logic              wr_valid_q;
  logic              wr_valid_d;

  logic [PIX_W-1:0]  red_q;
  logic [PIX_W-1:0]  green_q;
  logic [PIX_W-1:0]  blue_q;

  c2bw_pixel_counter #(
    .NPIX   (NPIX),
    .ADDR_W (ADDR_W)
  ) u_pixel_counter (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .addr_o (addr),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; strobes are decoded from state_d so they appear registered in that state.
  always_comb begin
    state_d    = state_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    load_en    = 1'b0;
    xfer       = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    wr_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          cnt_clr = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = bus.abort ? IDLE : LOAD;
      end
      LOAD: begin
        load_en = !bus.abort;
        state_d = bus.abort ? IDLE : WRITE;
      end
      WRITE: begin
        // A transfer coinciding with abort still completes, then the frame ends.
        if (bus.wrReady) begin
          xfer = 1'b1;
          if (bus.abort) begin
            state_d = IDLE;
          end else if (cnt_last) begin
            state_d = DONE;
          end else begin
            cnt_inc = 1'b1;
            state_d = FETCH;
          end
        end else if (bus.abort) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = state_busy(state_d);
    done_d     = (state_d == DONE);
    rd_en_d    = (state_d == FETCH);
    wr_valid_d = (state_d == WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  // Pixel register feeding Color2BW; memory data is valid in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (load_en) begin
      red_q   <= bus.rdRed;
      green_q <= bus.rdGreen;
      blue_q  <= bus.rdBlue;
    end
  end

`ifdef C2BW_CHECKSUM_EN
  logic [CHK_W-1:0] chk_q;
  logic [CHK_W-1:0] chk_d;

  always_comb begin
    chk_d = chk_q;
    if (cnt_clr) begin
      chk_d = '0;
    end else if (xfer) begin
      chk_d = chk_q + CHK_W'(bus.wrData);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign bus.checksum = chk_q;
`endif

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rdEn       = rd_en_q;
  assign bus.rdAddr     = addr;
  assign bus.colorRed   = red_q;
  assign bus.colorGreen = green_q;
  assign bus.colorBlue  = blue_q;
  assign bus.wrValid    = wr_valid_q;
  assign bus.wrAddr     = addr;
  // Grey byte comes back combinationally from Color2BW; gated so it is 0 outside WRITE.
  assign bus.wrData     = wr_valid_q ? bus.greyIn : '0;

endmodule

// File: tb/tb_c2bw_frame_sequencer.sv
// Self-checking bench for c2bw_frame_sequencer on a 4x2 frame with greyIn = colorRed.
// Honours C2BW_CHECKSUM_EN the same way as the design.
module tb_c2bw_frame_sequencer;

  localparam int unsigned FW   = 4;
  localparam int unsigned FH   = 2;
  localparam int unsigned NPIX = FW * FH;
  localparam int unsigned AW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  c2bw_seq_if #(.ADDR_W(AW)) bus ();

  c2bw_frame_sequencer #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .ADDR_W  (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem_r [NPIX];
  logic [7:0] mem_g [NPIX];
  logic [7:0] mem_b [NPIX];

  // Synchronous-read channel memories and a Color2BW stub.
  always @(posedge clk) begin
    if (bus.rdEn) begin
      bus.rdRed   <= mem_r[bus.rdAddr];
      bus.rdGreen <= mem_g[bus.rdAddr];
      bus.rdBlue  <= mem_b[bus.rdAddr];
    end
  end
  assign bus.greyIn = bus.colorRed;

  int n_tests = 0;
  int n_fail  = 0;

  int stall [NPIX];
  int start_cyc;
  int abort_cyc;
  int done_cnt;
  int done_cyc;
  logic [AW-1:0] wa_q [$];
  logic [7:0]    wd_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_done"},    32'(bus.done), 32'd0);
    chk({tag, "_rdEn"},    32'(bus.rdEn), 32'd0);
    chk({tag, "_rdAddr"},  32'(bus.rdAddr), 32'd0);
    chk({tag, "_color"},   {8'd0, bus.colorRed, bus.colorGreen, bus.colorBlue}, 32'd0);
    chk({tag, "_wrValid"}, 32'(bus.wrValid), 32'd0);
    chk({tag, "_wrAddr"},  32'(bus.wrAddr), 32'd0);
    chk({tag, "_wrData"},  32'(bus.wrData), 32'd0);
`ifdef C2BW_CHECKSUM_EN
    chk({tag, "_checksum"}, bus.checksum, 32'd0);
`endif
  endtask

  // Start a frame at edge 0 and act as output buffer for ncyc cycles.
  task automatic run(input int ncyc);
    int sl;
    int pix;
    logic hold;
    logic [AW-1:0] h_a;
    logic [7:0] h_d;
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    pix  = 0;
    sl   = stall[0];
    hold = 1'b0;
    h_a  = '0;
    h_d  = '0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    bus.wrReady = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus.start = (c == start_cyc);
      bus.abort = (c == abort_cyc);
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      chk("rd_wr_exclusive", 32'(bus.rdEn & bus.wrValid), 32'd0);
      if (bus.rdEn) chk("rdAddr", 32'(bus.rdAddr), 32'(pix));
      if (abort_cyc >= 0 && c == abort_cyc + 1) chk("busy_after_abort", 32'(bus.busy), 32'd0);
      if (hold) begin
        chk("hold_wrValid", 32'(bus.wrValid), 32'd1);
        chk("hold_wrAddr",  32'(bus.wrAddr), 32'(h_a));
        chk("hold_wrData",  32'(bus.wrData), 32'(h_d));
      end
      if (bus.wrValid) begin
        if (sl > 0) begin
          bus.wrReady = 1'b0;
          sl--;
          hold = 1'b1;
          h_a  = bus.wrAddr;
          h_d  = bus.wrData;
        end else begin
          bus.wrReady = 1'b1;
          hold = 1'b0;
          wa_q.push_back(bus.wrAddr);
          wd_q.push_back(bus.wrData);
          pix++;
          sl = (pix < int'(NPIX)) ? stall[pix] : 0;
        end
      end else begin
        bus.wrReady = 1'b1;
        hold = 1'b0;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  // Writes must be pixels 0..n-1 in order with the red channel as grey.
  task automatic check_frame(input string tag, input int exp_n, input int exp_dcnt, input int exp_dcyc);
    chk({tag, "_nwrites"}, 32'(wa_q.size()), 32'(exp_n));
    for (int i = 0; i < wa_q.size(); i++) begin
      chk({tag, "_wrAddr"}, 32'(wa_q[i]), 32'(i));
      chk({tag, "_wrData"}, 32'(wd_q[i]), 32'(mem_r[i]));
    end
    chk({tag, "_done_count"}, 32'(done_cnt), 32'(exp_dcnt));
    if (exp_dcnt > 0) chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_dcyc));
  endtask

  function automatic logic [31:0] sum_red(input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s += 32'(mem_r[i]);
    return s;
  endfunction

  function automatic int stall_total();
    int s = 0;
    for (int i = 0; i < int'(NPIX); i++) s += stall[i];
    return s;
  endfunction

  initial begin
    int tot;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.wrReady = 1'b1;
    start_cyc   = -1;
    abort_cyc   = -1;
    for (int i = 0; i < int'(NPIX); i++) begin
      mem_r[i] = 8'(16 * i);
      mem_g[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
      stall[i] = 0;
    end

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Full frame without backpressure.
    run(30);
    check_frame("full", 8, 1, 25);
`ifdef C2BW_CHECKSUM_EN
    chk("full_checksum", bus.checksum, 32'h1C0);
`endif
    chk("full_busy_idle", 32'(bus.busy), 32'd0);

    // Reset while idle clears held pixel and checksum.
    #1 rst = 1'b1;
    #1 chk_all_zero("rst_idle");
    @(negedge clk);
    rst = 1'b0;

    // Reset while a write is stalled.
    bus.wrReady = 1'b0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_wrValid", 32'(bus.wrValid), 32'd1);
    #1 rst = 1'b1;
    #1 chk_all_zero("rst_write");
    @(negedge clk);
    rst = 1'b0;
    bus.wrReady = 1'b1;
    @(negedge clk);
    chk("rst_stays_idle", 32'(bus.busy), 32'd0);

    // Backpressure: 5 stall cycles at pixel 3.
    stall[3] = 5;
    run(36);
    check_frame("bp", 8, 1, 30);
`ifdef C2BW_CHECKSUM_EN
    chk("bp_checksum", bus.checksum, 32'h1C0);
`endif
    stall[3] = 0;

    // Abort in LOAD of pixel 2 (cycle 8).
    abort_cyc = 8;
    run(14);
    check_frame("abort", 2, 0, 0);
`ifdef C2BW_CHECKSUM_EN
    chk("abort_checksum", bus.checksum, 32'h10);
`endif
    abort_cyc = -1;
    run(30);
    check_frame("after_abort", 8, 1, 25);

    // start during WRITE of pixel 4 (cycle 15) is ignored.
    start_cyc = 15;
    run(34);
    check_frame("start_ignored", 8, 1, 25);
    start_cyc = -1;

    // start together with abort in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 32'd0);
    chk("start_abort_rdEn", 32'(bus.rdEn), 32'd0);
    @(negedge clk);
    chk("start_abort_busy2", 32'(bus.busy), 32'd0);

    // Random pixels and random per-pixel backpressure.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(NPIX); i++) begin
        mem_r[i] = 8'($urandom);
        mem_g[i] = 8'($urandom);
        mem_b[i] = 8'($urandom);
        stall[i] = int'($urandom_range(0, 3));
      end
      tot = stall_total();
      run(3 * int'(NPIX) + tot + 4);
      check_frame("rand", 8, 1, 3 * int'(NPIX) + 1 + tot);
`ifdef C2BW_CHECKSUM_EN
      chk("rand_checksum", bus.checksum, sum_red(int'(NPIX)));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/c2bw_frame_sequencer.md
# c2bw_frame_sequencer

Frame sequencer for the Color2BW greyscale datapath. It walks a FRAME_W×FRAME_H image held in three 8-bit channel memories (red, green, blue), presents each pixel to an external Color2BW instance and writes the returned grey byte to an output buffer over a valid/ready port. It replaces bench-driven pixel loops and sits between the frame memories and the output buffer.

## Interface
- FRAME_W, 128, pixels per row
- FRAME_H, 128, rows per frame
- ADDR_W, 14, address width; must satisfy 2^ADDR_W ≥ FRAME_W*FRAME_H
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame request; accepted only in IDLE
- abort  in  1  terminate the current frame
- busy  out  1  high in FETCH, LOAD and WRITE
- done  out  1  one-cycle pulse when a frame completes
- rdEn  out  1  channel-memory read strobe
- rdAddr  out  ADDR_W  linear pixel address, row*FRAME_W+col
- rdRed, rdGreen, rdBlue  in  8  memory data, valid the cycle after rdEn
- colorRed, colorGreen, colorBlue  out  8  registered pixel, driven to Color2BW
- greyIn  in  8  Color2BW `out`, combinational from colorRed/Green/Blue
- wrValid  out  1  output write request
- wrReady  in  1  output buffer accepts
- wrAddr  out  ADDR_W  output address, equals the pixel address
- wrData  out  8  equals greyIn while wrValid is high
- checksum  out  32  present only with C2BW_CHECKSUM_EN

## Operation
- NPIX = FRAME_W*FRAME_H. One pixel counter `addr` runs 0..NPIX-1.
- IDLE: start=1 and abort=0 → addr=0, go to FETCH.
- FETCH: rdEn=1, rdAddr=addr → LOAD.
- LOAD: register rdRed/rdGreen/rdBlue into colorRed/colorGreen/colorBlue → WRITE.
- WRITE: wrValid=1, wrAddr=addr, wrData=greyIn. Hold until wrValid&&wrReady. On transfer: if addr==NPIX-1 → DONE, else addr+1 → FETCH.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- abort=1 in any non-IDLE state → IDLE next edge, no done pulse. A WRITE cycle with wrReady=1 and abort=1 counts as a completed transfer, then goes to IDLE.
- start while not in IDLE is ignored. start and abort together in IDLE leave the FSM in IDLE.
- wrValid must not drop, and wrAddr/wrData must not change, while waiting for wrReady.

## Timing
- Reset (async, any state): IDLE, addr=0. All outputs 0, including the color registers and checksum.
- A start accepted at edge 0 gives FETCH in cycle 1, LOAD in cycle 2 and WRITE in cycle 3.
- With no backpressure, each pixel takes 3 cycles.
- done is high in cycle 3*NPIX+1; each wrReady-low cycle adds one cycle.
- rdEn is never asserted outside FETCH. wrValid is never asserted outside WRITE.

## Configuration
- C2BW_CHECKSUM_EN defined:
  - 32-bit checksum port is present.
  - It clears on an accepted start and adds wrData on every write transfer, wrapping modulo 2^32.
  - It holds its value after done or abort until the next start.
- C2BW_CHECKSUM_EN undefined: no port and no accumulator logic.

## Structure
- Package c2bw_pkg: state enum (IDLE, FETCH, LOAD, WRITE, DONE), PIX_W=8 and CHK_W=32.
- Sub-module c2bw_pixel_counter: addr register with clear, increment and a last flag (addr==NPIX-1).
- Color2BW is instantiated by the integrating level, not inside this block.

## Test plan
All tests use FRAME_W=4, FRAME_H=2 (NPIX=8) and a bench stub greyIn=colorRed. Red memory holds 0x10*i.
- Reset: assert rst mid-WRITE → all outputs 0 immediately, FSM in IDLE; a following start runs from addr 0.
- Full frame, wrReady=1: 8 writes at addr 0..7 with data 00,10,…,70. done pulses in cycle 25. checksum=0x1C0.
- Backpressure: wrReady=0 for 5 cycles at addr 3 → wrValid, wrAddr=3 and wrData=0x30 held stable; done moves to cycle 30; checksum still 0x1C0.
- Abort in LOAD of addr 2: no write to addr 2, busy=0 next cycle, no done. A later start rewrites addr 0..7.
- start pulsed during WRITE of addr 4 is ignored: exactly 8 writes and one done. start+abort in IDLE: busy stays 0.
- Build without C2BW_CHECKSUM_EN: full-frame test passes identically and the checksum port is absent.
